// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (sync, 16-bit word count,
// big-endian words, XOR checksum), writes the words sequentially into the
// instruction memory starting at word 0, and releases the CPU from reset only
// after a complete image with a matching checksum has been loaded.
module imem_loader #(
    parameter int          ADDR_WIDTH = 13,
    parameter int          DATA_WIDTH = 32,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    // Memory capacity in words; a count equal to this is still legal.
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    // One bit wider than the address so a full-memory count is representable.
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d;

    logic                  accept;
    logic [15:0]           len_full;

    assign accept   = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
        end
    end

    // Next-state and datapath update; start overrides every transition.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        csum_d  = csum_q;

        if (start) begin
            state_d = IDLE;
            len_d   = '0;
            idx_d   = '0;
            bcnt_d  = '0;
            word_d  = '0;
            csum_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && in_data == SYNC_BYTE) state_d = LEN_HI;
                end
                LEN_HI: begin
                    if (accept) begin
                        len_d[15:8] = in_data;
                        state_d     = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_d[7:0] = in_data;
                        if (33'(len_full) > CAPACITY) state_d = ERR;
                        else if (len_full == 16'd0)   state_d = CSUM;
                        else                          state_d = DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_d = (word_q << 8) | DATA_WIDTH'(in_data);
                        csum_d = csum_q ^ in_data;
                        if (bcnt_q == LAST_BYTE) begin
                            bcnt_d  = '0;
                            state_d = WRITE;
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    idx_d = idx_q + 1'b1;
                    if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = CSUM;
                    else                                  state_d = DATA;
                end
                CSUM: begin
                    if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
                end
                DONE:    state_d = DONE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded purely from the current state.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            IDLE, LEN_HI, LEN_LO, DATA, CSUM: in_ready = 1'b1;
            WRITE:   mem_we = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:     error = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign mem_addr  = idx_q[ADDR_WIDTH-1:0];
    assign mem_wdata = word_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: frames are driven byte by byte over the
// valid/ready handshake, memory writes are collected by a monitor, and each
// scenario task compares the writes and status outputs with hand-derived values.
module tb_imem_loader;

    localparam int AW = 13;
    localparam int DW = 32;

    typedef logic [7:0]     byte_q_t[$];
    typedef logic [AW+DW-1:0] wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int  cmp_count = 0;
    int  err_count = 0;
    wr_t wr_q[$];
    int  we_bad = 0;
    logic we_prev = 1'b0;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Record every write; flag writes that coincide with in_ready or last >1 cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_q.push_back({mem_addr, mem_wdata});
            if (in_ready !== 1'b0) we_bad++;
            if (we_prev === 1'b1) we_bad++;
        end
        we_prev = mem_we;
    end

    // Present one byte and return at posedge+1 once it has been accepted.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int gap;
        if (stall) begin
            gap = $urandom_range(0, 2);
            in_valid = 1'b0;
            for (int i = 0; i < gap; i++) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        cmp_count++;
        err_count++;
        $display("FAIL send_byte_timeout: byte %h never accepted, in_ready=%b", b, in_ready);
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t s, input bit stall);
        foreach (s[i]) send_byte(s[i], stall);
        in_valid = 1'b0;
    endtask

    // One-cycle start pulse with a sync byte offered in the same cycle.
    task automatic pulse_start();
        start    = 1'b1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        wr_q.delete();
        we_bad = 0;
    endtask

    // Status vector order: {in_ready, mem_we, cpu_hold, done, error}
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100) begin
            err_count++;
            $display("FAIL reset_status: got %b want 10100", {in_ready, mem_we, cpu_hold, done, error});
        end
        cmp_count++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            err_count++;
            $display("FAIL reset_mem_bus: got addr=%h data=%h want 0/0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wr_q.delete();
        we_bad = 0;
    endtask

    // Two-word frame; XOR of the eight data bytes is 0x22.
    task automatic test_two_words();
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
        cmp_count++;
        if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 13'd0, 32'hDEADBEEF}) begin
            err_count++;
            $display("FAIL write0_latency: got we=%b rdy=%b addr=%h data=%h want 1 0 0000 deadbeef",
                     mem_we, in_ready, mem_addr, mem_wdata);
        end
        send_seq('{8'h01, 8'h23, 8'h45, 8'h67}, 1'b0);
        cmp_count++;
        if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 13'd1, 32'h01234567}) begin
            err_count++;
            $display("FAIL write1_latency: got we=%b rdy=%b addr=%h data=%h want 1 0 0001 01234567",
                     mem_we, in_ready, mem_addr, mem_wdata);
        end
        send_seq('{8'h22}, 1'b0);
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b00010) begin
            err_count++;
            $display("FAIL two_words_status: got %b want 00010", {in_ready, mem_we, cpu_hold, done, error});
        end
        cmp_count++;
        if (wr_q.size() != 2 || wr_q[0] !== {13'd0, 32'hDEADBEEF} || wr_q[1] !== {13'd1, 32'h01234567}) begin
            err_count++;
            $display("FAIL two_words_writes: got %0d writes want 2 (0:deadbeef 1:01234567)", wr_q.size());
        end
        cmp_count++;
        if (we_bad != 0) begin
            err_count++;
            $display("FAIL two_words_we_shape: got %0d bad write cycles want 0", we_bad);
        end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h01, 8'h23, 8'h45, 8'h67, 8'h44}, 1'b0);
        cmp_count++;
        if (wr_q.size() != 2 || wr_q[0] !== {13'd0, 32'hDEADBEEF} || wr_q[1] !== {13'd1, 32'h01234567}) begin
            err_count++;
            $display("FAIL bad_csum_writes: got %0d writes want 2", wr_q.size());
        end
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b00101) begin
            err_count++;
            $display("FAIL bad_csum_status: got %b want 00101", {in_ready, mem_we, cpu_hold, done, error});
        end
        repeat (4) @(posedge clk);
        #1;
        cmp_count++;
        if ({in_ready, cpu_hold, done, error} !== 4'b0101) begin
            err_count++;
            $display("FAIL bad_csum_held: got %b want 0101", {in_ready, cpu_hold, done, error});
        end
    endtask

    // Leading garbage is dropped, then an empty image with checksum 0.
    task automatic test_garbage_empty();
        pulse_start();
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        cmp_count++;
        if (wr_q.size() != 0) begin
            err_count++;
            $display("FAIL empty_writes: got %0d writes want 0", wr_q.size());
        end
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b00010) begin
            err_count++;
            $display("FAIL empty_status: got %b want 00010", {in_ready, mem_we, cpu_hold, done, error});
        end
    endtask

    // 0x2001 exceeds 8192 words; 0x2000 is exactly full and accepted.
    task automatic test_length_bounds();
        pulse_start();
        send_seq('{8'hA5, 8'h20, 8'h01}, 1'b0);
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b00101 || wr_q.size() != 0) begin
            err_count++;
            $display("FAIL len_overflow: got status=%b writes=%0d want 00101 0",
                     {in_ready, mem_we, cpu_hold, done, error}, wr_q.size());
        end
        pulse_start();
        send_seq('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 1'b0);
        cmp_count++;
        if (wr_q.size() != 1 || wr_q[0] !== {13'd0, 32'h12345678} || done !== 1'b1) begin
            err_count++;
            $display("FAIL reload_after_err: got writes=%0d done=%b want 1 write 12345678, done=1",
                     wr_q.size(), done);
        end
        pulse_start();
        send_seq('{8'hA5, 8'h20, 8'h00}, 1'b0);
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100) begin
            err_count++;
            $display("FAIL len_full_legal: got %b want 10100", {in_ready, mem_we, cpu_hold, done, error});
        end
    endtask

    // Three-word frame, checksum 0xCC, sent once without and once with gaps.
    task automatic test_back_to_back_and_stall();
        byte_q_t f;
        f = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            send_seq(f, pass == 1);
            cmp_count++;
            if (wr_q.size() != 3 || wr_q[0] !== {13'd0, 32'h11223344} ||
                wr_q[1] !== {13'd1, 32'h55667788} || wr_q[2] !== {13'd2, 32'h99AABBCC}) begin
                err_count++;
                $display("FAIL three_words_writes pass %0d: got %0d writes want 3", pass, wr_q.size());
            end
            cmp_count++;
            if (done !== 1'b1 || cpu_hold !== 1'b0 || we_bad != 0) begin
                err_count++;
                $display("FAIL three_words_done pass %0d: got done=%b hold=%b bad_we=%0d want 1 0 0",
                         pass, done, cpu_hold, we_bad);
            end
        end
    endtask

    // Abort a frame after five data bytes, then load a fresh one-word image.
    task automatic test_start_abort();
        pulse_start();
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01}, 1'b0);
        pulse_start();
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100 || mem_wdata !== '0 || mem_addr !== '0) begin
            err_count++;
            $display("FAIL start_clears: got status=%b addr=%h data=%h want 10100 0 0",
                     {in_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata);
        end
        send_seq('{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30}, 1'b0);
        cmp_count++;
        if (wr_q.size() != 1 || wr_q[0] !== {13'd0, 32'hCAFEBABE} || done !== 1'b1) begin
            err_count++;
            $display("FAIL start_reload: got writes=%0d done=%b want 1 write cafebabe@0, done=1",
                     wr_q.size(), done);
        end
    endtask

    // Asynchronous reset mid-word must clear outputs without waiting for a clock edge.
    task automatic test_rst_mid_frame();
        pulse_start();
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE}, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cmp_count++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100 || mem_addr !== '0 || mem_wdata !== '0) begin
            err_count++;
            $display("FAIL async_rst: got status=%b addr=%h data=%h want 10100 0 0",
                     {in_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        wr_q.delete();
        we_bad = 0;
        send_seq('{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30}, 1'b0);
        cmp_count++;
        if (wr_q.size() != 1 || wr_q[0] !== {13'd0, 32'hCAFEBABE} || done !== 1'b1) begin
            err_count++;
            $display("FAIL rst_reload: got writes=%0d done=%b want 1 write cafebabe@0, done=1",
                     wr_q.size(), done);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_bad_checksum();
        test_garbage_empty();
        test_length_bounds();
        test_back_to_back_and_stall();
        test_start_abort();
        test_rst_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
